// File: rtl/kernel_pr_ctrl_pkg.sv
// Shared definitions for the kernel process-region start/done controllers:
// the 2-bit FSM state encoding and the default widths.
package kernel_pr_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 1;
  localparam int DEF_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/kernel_pr_write_back_start_ctrl.sv
// Start/done sequencer for the write_back process: pops a start token, runs
// one ap_start/ap_ready/ap_done/ap_continue iteration, pushes a done token,
// and chains straight into the next iteration when a token is waiting.
//
// Handshakes: a FIFO pop happens on a cycle where start_if_read=1 and
// start_if_empty_n=1; a FIFO push happens on a cycle where done_if_write=1 and
// done_if_full_n=1. start_if_read and done_if_write are only ever raised when
// their qualifying flag is already high, so every assertion is a transfer.
// ap_start is held until ap_ready is sampled high; ap_continue is a one-cycle
// acknowledge of the (level) ap_done, issued in the cycle the done token is
// pushed.
module kernel_pr_write_back_start_ctrl
  import kernel_pr_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start_if_empty_n,
  input  logic [DATA_WIDTH-1:0] start_if_dout,
  output logic                  start_if_read,
  output logic                  start_if_read_ce,
  output logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  output logic                  ap_continue,
  output logic [DATA_WIDTH-1:0] token_q,
  input  logic                  done_if_full_n,
  output logic                  done_if_write,
  output logic                  done_if_write_ce,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  done_count,
  output logic [1:0]            state_dbg
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  ctrl_state_e state;

  logic run;
  logic pop_idle;
  logic done_fire;

  // Reset overrides everything, so no pop or push can slip out in the reset cycle.
  assign run       = ce & ~reset;
  assign pop_idle  = run & start_if_empty_n & (state == S_IDLE);
  assign done_fire = run & done_if_full_n & (state == S_DONE);

  // Outputs decoded from the registered state plus the qualifying inputs.
  assign start_if_read    = pop_idle | (done_fire & start_if_empty_n);
  assign ap_continue      = done_fire;
  assign done_if_write    = done_fire;
  assign ap_start         = ~reset & (state == S_START);
  assign busy             = ~reset & (state != S_IDLE);
  assign start_if_read_ce = ce;
  assign done_if_write_ce = ce;
  assign state_dbg        = state;

  // Iteration FSM, captured token and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      token_q    <= '0;
      done_count <= '0;
    end else if (ce) begin
      if (start_if_read) begin
        token_q <= start_if_dout;
      end
      case (state)
        S_IDLE: begin
          if (start_if_empty_n) begin
            state <= S_START;
          end
        end
        S_START: begin
          // ap_done arriving with ap_ready skips the wait state entirely.
          if (ap_ready) begin
            state <= ap_done ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (ap_done) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (done_if_full_n) begin
            done_count <= done_count + CNT_ONE;
            // Zero-bubble chaining: the next token is popped on completion.
            state      <= start_if_empty_n ? S_START : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_pr_write_back_start_ctrl.sv
// Directed bench for kernel_pr_write_back_start_ctrl: a per-cycle vector table
// for a single iteration, then hand-written sequences with a start-FIFO model
// for chaining, backpressure, reset mid-iteration, ce hold and counter wrap.
module tb_kernel_pr_write_back_start_ctrl;
  import kernel_pr_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          ce;
  logic          start_if_empty_n;
  logic [DW-1:0] start_if_dout;
  logic          start_if_read;
  logic          start_if_read_ce;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_done;
  logic          ap_continue;
  logic [DW-1:0] token_q;
  logic          done_if_full_n;
  logic          done_if_write;
  logic          done_if_write_ce;
  logic          busy;
  logic [CW-1:0] done_count;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  kernel_pr_write_back_start_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .ce               (ce),
    .start_if_empty_n (start_if_empty_n),
    .start_if_dout    (start_if_dout),
    .start_if_read    (start_if_read),
    .start_if_read_ce (start_if_read_ce),
    .ap_start         (ap_start),
    .ap_ready         (ap_ready),
    .ap_done          (ap_done),
    .ap_continue      (ap_continue),
    .token_q          (token_q),
    .done_if_full_n   (done_if_full_n),
    .done_if_write    (done_if_write),
    .done_if_write_ce (done_if_write_ce),
    .busy             (busy),
    .done_count       (done_count),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [DW-1:0] fifo_q[$];
  int          pops;
  int          pushes;
  int          viol;
  logic [7:0]  start_hist;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: drive at negedge, sample 2ns later, update the FIFO model.
  task automatic step(input logic rst, input logic c, input logic rdy,
                      input logic dn, input logic fn);
    @(negedge clk);
    reset            = rst;
    ce               = c;
    ap_ready         = rdy;
    ap_done          = dn;
    done_if_full_n   = fn;
    start_if_empty_n = (fifo_q.size() != 0);
    start_if_dout    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #2;
    if (start_if_read && !start_if_empty_n) viol++;
    if (done_if_write && !done_if_full_n)   viol++;
    if (start_if_read && start_if_empty_n) begin
      pops++;
      void'(fifo_q.pop_front());
    end
    if (done_if_write && done_if_full_n) pushes++;
    start_hist = {start_hist[6:0], ap_start};
  endtask

  task automatic do_reset();
    fifo_q.delete();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pops = 0; pushes = 0; viol = 0; start_hist = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          ce, empty_n;
    logic [DW-1:0] dout;
    logic          rdy, dn, full_n;
    logic          e_read, e_start, e_cont, e_write, e_busy;
    logic [CW-1:0] e_cnt;
    logic [DW-1:0] e_tok;
  } vec_t;

  vec_t vt[8];

  function automatic vec_t mk(input logic c, input logic en, input logic [DW-1:0] d,
                              input logic r, input logic dn, input logic fn,
                              input logic er, input logic es, input logic ec,
                              input logic ew, input logic eb, input logic [CW-1:0] cnt,
                              input logic [DW-1:0] tok);
    vec_t v;
    v.ce = c; v.empty_n = en; v.dout = d; v.rdy = r; v.dn = dn; v.full_n = fn;
    v.e_read = er; v.e_start = es; v.e_cont = ec; v.e_write = ew; v.e_busy = eb;
    v.e_cnt = cnt; v.e_tok = tok;
    return v;
  endfunction

  logic rd_seen, ce_seen, bp_seen, seen15;
  int   cyc;

  initial begin
    reset = 1'b1; ce = 1'b0; start_if_empty_n = 1'b0; start_if_dout = '0;
    ap_ready = 1'b0; ap_done = 1'b0; done_if_full_n = 1'b1;
    pops = 0; pushes = 0; viol = 0; start_hist = '0;

    // Single iteration: token 1, ap_ready in cycle 3, ap_done from cycle 6.
    //         ce en dout rdy dn fn | rd st co wr by cnt tok
    vt[0] = mk(1, 1, 8'd1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 8'd0);
    vt[1] = mk(1, 0, 8'd0, 0, 0, 1,   0, 1, 0, 0, 1, 0, 8'd1);
    vt[2] = mk(1, 0, 8'd0, 1, 0, 1,   0, 1, 0, 0, 1, 0, 8'd1);
    vt[3] = mk(1, 0, 8'd0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 8'd1);
    vt[4] = mk(1, 0, 8'd0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 8'd1);
    vt[5] = mk(1, 0, 8'd0, 0, 1, 1,   0, 0, 0, 0, 1, 0, 8'd1);
    vt[6] = mk(1, 0, 8'd0, 0, 1, 1,   0, 0, 1, 1, 1, 0, 8'd1);
    vt[7] = mk(1, 0, 8'd0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 8'd1);

    // ---- reset state ----
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_state", 32'(state_dbg), 32'(S_IDLE));
    check("reset_outputs", {27'd0, start_if_read, ap_start, ap_continue, done_if_write, busy}, 32'd0);
    check("reset_regs", {20'd0, done_count, token_q}, 32'd0);

    // ---- table: single iteration ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset = 1'b0; ce = vt[i].ce; start_if_empty_n = vt[i].empty_n;
      start_if_dout = vt[i].dout; ap_ready = vt[i].rdy; ap_done = vt[i].dn;
      done_if_full_n = vt[i].full_n;
      #2;
      check($sformatf("single_cyc%0d", i + 1),
            {15'd0, start_if_read, ap_start, ap_continue, done_if_write, busy, done_count, token_q},
            {15'd0, vt[i].e_read, vt[i].e_start, vt[i].e_cont, vt[i].e_write, vt[i].e_busy,
             vt[i].e_cnt, vt[i].e_tok});
    end

    // ---- three tokens, back-to-back ----
    do_reset();
    fifo_q.push_back(8'hA1); fifo_q.push_back(8'hB2); fifo_q.push_back(8'hC3);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("b2b_pops", 32'(pops), 32'd3);
    check("b2b_pushes", 32'(pushes), 32'd3);
    check("b2b_count", 32'(done_count), 32'd3);
    check("b2b_ap_start_pattern", 32'(start_hist), 32'h54);
    check("b2b_last_token", 32'(token_q), 32'hC3);
    check("b2b_handshake_rules", 32'(viol), 32'd0);

    // ---- backpressure in S_DONE ----
    do_reset();
    fifo_q.push_back(8'h05); fifo_q.push_back(8'h06);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);   // pop
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);   // S_START -> S_DONE
    bp_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      bp_seen = bp_seen | ap_continue | done_if_write | start_if_read;
    end
    check("bp_no_ack_or_pop", 32'(bp_seen), 32'd0);
    check("bp_state_held", 32'(state_dbg), 32'(S_DONE));
    check("bp_pops_held", 32'(pops), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);   // space appears: push + chained pop
    check("bp_release_ack", {30'd0, ap_continue, done_if_write}, 32'd3);
    check("bp_release_counts", {16'(pushes), 16'(pops)}, {16'd1, 16'd2});
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("bp_chained_start", {30'd0, ap_start, 1'(done_count == 4'd1)}, 32'd3);
    check("bp_handshake_rules", 32'(viol), 32'd0);

    // ---- reset while in S_WAIT ----
    do_reset();
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);   // pop
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);   // S_START -> S_WAIT
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_pre_state", 32'(state_dbg), 32'(S_WAIT));
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);   // reset with ap_done present
    check("rst_cycle_no_xfer", {30'd0, start_if_read, done_if_write}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_after_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_after_outputs",
          {27'd0, start_if_read, ap_start, ap_continue, done_if_write, busy}, 32'd0);
    check("rst_after_regs", {20'd0, done_count, token_q}, 32'd0);
    check("rst_fifo_kept", {16'(fifo_q.size()), 16'(pushes)}, {16'd2, 16'd0});

    // ---- ce low holds the FSM ----
    do_reset();
    fifo_q.push_back(8'h7E);
    rd_seen = 1'b0; ce_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rd_seen = rd_seen | start_if_read;
      ce_seen = ce_seen | start_if_read_ce | done_if_write_ce;
    end
    check("ce_low_no_pop", {30'd0, rd_seen, ce_seen}, 32'd0);
    check("ce_low_state", {16'(state_dbg), 16'(fifo_q.size())}, {16'(S_IDLE), 16'd1});
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("ce_high_pop", {16'(pops), 15'd0, start_if_read_ce}, {16'd1, 15'd0, 1'b1});

    // ---- counter wrap at 2^CW ----
    do_reset();
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
    seen15 = 1'b0;
    cyc = 0;
    while (pushes < 16 && cyc < 80) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      if (done_count == 4'd15) seen15 = 1'b1;
      cyc++;
    end
    check("wrap_all_pushed_in_budget", 32'(pushes), 32'd16);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("wrap_reached_15", 32'(seen15), 32'd1);
    check("wrap_count_zero", 32'(done_count), 32'd0);
    check("wrap_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
